// File: rtl/mii_rx_stream_buffer.sv
// mii_rx_stream_buffer
//   MII nibble receiver that strips preamble/SFD, packs bytes little-endian into
//   DATA_WIDTH words in a circular frame buffer, queues committed frame lengths in
//   a descriptor FIFO and streams committed frames out on AXI-Stream.
//   Optional CRC-32 frame check: define FCS_CHECK_EN.
module mii_rx_stream_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int BUF_DEPTH       = 512,
  parameter int MAX_FRAMES      = 4,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    phy_nibble_valid,
  input  logic                    phy_dv,
  input  logic                    phy_rx_er,
  input  logic [3:0]              phy_rx_data,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [15:0]             frames_received,
  output logic [15:0]             frames_dropped,
  output logic                    rx_busy
);
  localparam int BW     = DATA_WIDTH / 8;
  localparam int LANE_W = (BW > 1) ? $clog2(BW) : 1;
  localparam int AW     = $clog2(BUF_DEPTH);
  localparam int FW     = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_PREAMBLE, RX_DATA, RX_DROP} rx_state_t;
  rx_state_t state, state_next;

  // frame buffer and pointers: frame_ptr = start of the frame being received
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]         frame_ptr, cur_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] word_acc, word_merged;
  logic [LANE_W-1:0]     lane;
  logic                  phase;
  logic [3:0]            low_nib;
  logic [LEN_W-1:0]      byte_cnt, len_next;

  // descriptor FIFO
  logic [LEN_W-1:0] desc_mem [MAX_FRAMES];
  logic [FW-1:0]    desc_wp, desc_rp;
  logic [FW:0]      desc_cnt;
  logic             desc_full, desc_empty, push, pop;

  // RX decision terms
  logic nib_data, byte_step, end_nib, lane_last, buf_full, too_long;
  logic byte_bad, commit_bad, fcs_bad;
  logic start_frame, byte_ok, word_wr, flush_wr, commit, drop;

  // TX
  logic             tx_run, load, rem_last;
  logic [LEN_W-1:0] tx_rem;
  logic [BW-1:0]    last_keep;

  function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
    return (p == FW'(MAX_FRAMES - 1)) ? '0 : p + FW'(1);
  endfunction

  assign desc_full  = (desc_cnt == (FW+1)'(MAX_FRAMES));
  assign desc_empty = (desc_cnt == '0);
  assign len_next   = byte_cnt + LEN_W'(1);
  assign lane_last  = (lane == LANE_W'(BW - 1));
  assign buf_full   = ((cur_ptr + AW'(1)) == rd_ptr);
  assign too_long   = (len_next > LEN_W'(MAX_FRAME_BYTES));
  assign nib_data   = phy_nibble_valid & (state == RX_DATA) & phy_dv;
  assign byte_step  = nib_data & ~phy_rx_er & phase;
  assign end_nib    = phy_nibble_valid & (state == RX_DATA) & ~phy_dv;
  assign byte_bad   = too_long | (lane_last & buf_full);
  assign commit_bad = phase | (byte_cnt == '0) | fcs_bad | ((lane != '0) & buf_full);
  assign rx_busy    = (state != RX_IDLE);

  // current byte merged into its lane of the accumulating word
  always_comb begin
    word_merged = word_acc;
    word_merged[int'(lane)*8 +: 8] = {phy_rx_data, low_nib};
  end

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_next;
  end

  // RX next state; only strobed nibbles move the FSM
  always_comb begin
    state_next = state;
    if (phy_nibble_valid) begin
      unique case (state)
        RX_IDLE:
          if (phy_dv) state_next = (phy_rx_data == 4'h5) ? RX_PREAMBLE : RX_DROP;
        RX_PREAMBLE:
          if (!phy_dv)                     state_next = RX_IDLE;
          else if (phy_rx_er)              state_next = RX_DROP;
          else if (phy_rx_data == 4'h5)    state_next = RX_PREAMBLE;
          else if (phy_rx_data == 4'hD && !desc_full) state_next = RX_DATA;
          else                             state_next = RX_DROP;
        RX_DATA:
          if (!phy_dv)                            state_next = RX_IDLE;
          else if (phy_rx_er || (phase && byte_bad)) state_next = RX_DROP;
        RX_DROP:
          if (!phy_dv) state_next = RX_IDLE;
      endcase
    end
  end

  // RX actions; a drop ending on dv=0 goes straight to IDLE but still counts
  always_comb begin
    start_frame = phy_nibble_valid & (state == RX_PREAMBLE) & phy_dv & ~phy_rx_er &
                  (phy_rx_data == 4'hD) & ~desc_full;
    byte_ok     = byte_step & ~byte_bad;
    word_wr     = byte_ok & lane_last;
    commit      = end_nib & ~commit_bad;
    flush_wr    = commit & (lane != '0);
    drop        = ((state_next == RX_DROP) && (state != RX_DROP)) | (end_nib & commit_bad);
  end

  // RX datapath: byte packing, pointer advance, rewind on drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_ptr <= '0;
      cur_ptr   <= '0;
      lane      <= '0;
      phase     <= 1'b0;
      low_nib   <= '0;
      byte_cnt  <= '0;
      word_acc  <= '0;
    end else if (start_frame) begin
      cur_ptr  <= frame_ptr;
      lane     <= '0;
      phase    <= 1'b0;
      byte_cnt <= '0;
      word_acc <= '0;
    end else if (drop) begin
      cur_ptr <= frame_ptr;
    end else if (commit) begin
      frame_ptr <= cur_ptr + AW'(flush_wr);
      cur_ptr   <= cur_ptr + AW'(flush_wr);
    end else if (nib_data && !phy_rx_er && !phase) begin
      low_nib <= phy_rx_data;
      phase   <= 1'b1;
    end else if (byte_ok) begin
      phase    <= 1'b0;
      byte_cnt <= len_next;
      if (lane_last) begin
        cur_ptr  <= cur_ptr + AW'(1);
        lane     <= '0;
        word_acc <= '0;
      end else begin
        word_acc <= word_merged;
        lane     <= lane + LANE_W'(1);
      end
    end
  end

  // frame buffer write port: full words and the commit-time partial flush
  always_ff @(posedge clk) begin
    if (word_wr || flush_wr) mem[cur_ptr] <= word_wr ? word_merged : word_acc;
  end

`ifdef FCS_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int unsigned k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // running CRC over DATA bytes, FCS included, so a good frame leaves the residue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           crc <= '1;
    else if (start_frame) crc <= '1;
    else if (byte_ok)     crc <= crc_byte(crc, {phy_rx_data, low_nib});
  end

  assign fcs_bad = (crc != 32'hDEBB20E3);
`else
  assign fcs_bad = 1'b0;
`endif

  assign push = commit;
  assign pop  = m_tvalid & m_tready & m_tlast;

  // descriptor FIFO storage
  always_ff @(posedge clk) begin
    if (push) desc_mem[desc_wp] <= byte_cnt;
  end

  // descriptor FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      desc_wp  <= '0;
      desc_rp  <= '0;
      desc_cnt <= '0;
    end else begin
      if (push) desc_wp <= fifo_inc(desc_wp);
      if (pop)  desc_rp <= fifo_inc(desc_rp);
      if (push && !pop)      desc_cnt <= desc_cnt + (FW+1)'(1);
      else if (pop && !push) desc_cnt <= desc_cnt - (FW+1)'(1);
    end
  end

  // saturating frame statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_received <= '0;
      frames_dropped  <= '0;
    end else begin
      if (push && frames_received != 16'hFFFF) frames_received <= frames_received + 16'd1;
      if (drop && frames_dropped != 16'hFFFF)  frames_dropped  <= frames_dropped + 16'd1;
    end
  end

  assign load     = tx_run & (~m_tvalid | m_tready);
  assign rem_last = (tx_rem <= LEN_W'(BW));

  // byte enables for the final beat of a frame
  always_comb begin
    last_keep = '0;
    for (int unsigned i = 0; i < BW; i++) last_keep[i] = (LEN_W'(i) < tx_rem);
  end

  // TX: fetch head descriptor once the previous frame is fully handed off,
  // then load one beat per free/accepted output slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_run   <= 1'b0;
      tx_rem   <= '0;
      rd_ptr   <= '0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else begin
      if (!tx_run && !m_tvalid && !desc_empty) begin
        tx_run <= 1'b1;
        tx_rem <= desc_mem[desc_rp];
      end
      if (load) begin
        m_tdata  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
        m_tvalid <= 1'b1;
        m_tlast  <= rem_last;
        m_tkeep  <= rem_last ? last_keep : '1;
        if (rem_last) tx_run <= 1'b0;
        else          tx_rem <= tx_rem - LEN_W'(BW);
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end
  end
endmodule
